// File: rtl/sig_cmn_pkg.sv
// sig_cmn_pkg: shared types and helpers for the credit-flow-controlled link.
package sig_cmn_pkg;
  typedef enum logic [1:0] {CTX_INIT, CTX_RUN, CTX_DRAIN} credit_tx_state_e;
  function automatic int credit_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/sig_cmn_rv_credit_tx_if.sv
// sig_cmn_rv_credit_tx_if: upstream valid/ready, link and credit signals of the credit transmitter.
interface sig_cmn_rv_credit_tx_if #(
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 4
);
  logic valid_in, ready_out;
  logic [DWIDTH-1:0] data_in;
  logic link_valid_out;
  logic [DWIDTH-1:0] link_data_out;
  logic credit_ret_in, reinit_req_in, reinit_done_out, err_out;
  logic [CWIDTH-1:0] credits_out;
  modport slave (
    input valid_in, data_in, credit_ret_in, reinit_req_in,
    output ready_out, link_valid_out, link_data_out, reinit_done_out, credits_out, err_out
  );
  modport master (
    output valid_in, data_in, credit_ret_in, reinit_req_in,
    input ready_out, link_valid_out, link_data_out, reinit_done_out, credits_out, err_out
  );
endinterface

// File: rtl/sig_cmn_credit_counter.sv
// sig_cmn_credit_counter: up/down credit counter with load-to-max and saturation at max.
module sig_cmn_credit_counter
  import sig_cmn_pkg::*;
#(
  parameter int MAX = 8,
  parameter int W = credit_width(MAX)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         sat
);
  logic [W-1:0] count_q, count_d;
  logic [W:0] sum;
  always_comb begin
    sum = {1'b0, count_q} + (W+1)'(inc) - (W+1)'(dec);
    sat = !load && sum > (W+1)'(MAX);
    count_d = (load || sat) ? W'(MAX) : sum[W-1:0];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/sig_cmn_rv_credit_tx.sv
// sig_cmn_rv_credit_tx: valid/ready to credit-flow-controlled link transmitter with drain/reinit.
// Optional sticky overflow error and send-without-credit assertion under SIG_CMN_CREDIT_TX_ERR_EN.
module sig_cmn_rv_credit_tx
  import sig_cmn_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int NUM_CREDITS = 8
) (
  input logic clk,
  input logic reset_n,
  sig_cmn_rv_credit_tx_if.slave io
);
  localparam int CWIDTH = credit_width(NUM_CREDITS);
  credit_tx_state_e state_q, state_d;
  logic link_valid_q, link_valid_d, done_q, done_d;
  logic [DWIDTH-1:0] link_data_q, link_data_d;
  logic [CWIDTH-1:0] credits;
  logic ready, send, load, full, sat;
  always_comb begin
    full = credits == CWIDTH'(NUM_CREDITS);
    load = state_q == CTX_INIT;
    ready = state_q == CTX_RUN && credits != '0 && !io.reinit_req_in;
    send = io.valid_in && ready;
    state_d = load ? CTX_RUN :
              state_q == CTX_RUN ? (io.reinit_req_in ? CTX_DRAIN : CTX_RUN) :
              (full ? CTX_INIT : CTX_DRAIN);
    link_valid_d = send;
    link_data_d = send ? io.data_in : link_data_q;
    done_d = load;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= CTX_INIT;
      link_valid_q <= 1'b0;
      link_data_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      link_valid_q <= link_valid_d;
      link_data_q <= link_data_d;
      done_q <= done_d;
    end
  // INIT's reload wins over a same-cycle return, so the return is masked there.
  sig_cmn_credit_counter #(.MAX(NUM_CREDITS), .W(CWIDTH)) u_cnt (
    .clk(clk), .reset_n(reset_n), .load(load), .inc(io.credit_ret_in && !load),
    .dec(send), .count(credits), .sat(sat)
  );
`ifdef SIG_CMN_CREDIT_TX_ERR_EN
  logic err_q, err_d;
  always_comb err_d = err_q || sat || (io.credit_ret_in && load);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) err_q <= 1'b0;
    else err_q <= err_d;
  always_ff @(posedge clk)
    if (reset_n) assert (!(send && credits == '0));
  assign io.err_out = err_q;
`else
  logic unused_sat;
  assign unused_sat = sat;
  assign io.err_out = 1'b0;
`endif
  assign io.ready_out = ready;
  assign io.link_valid_out = link_valid_q;
  assign io.link_data_out = link_data_q;
  assign io.reinit_done_out = done_q;
  assign io.credits_out = credits;
endmodule

// File: tb/tb_sig_cmn_rv_credit_tx.sv
// tb_sig_cmn_rv_credit_tx: directed and random checks of the credit transmitter against a behavioural model.
module tb_sig_cmn_rv_credit_tx;
  import sig_cmn_pkg::*;
  localparam int DW = 32;
  localparam int N = 8;
  localparam int CW = credit_width(N);
`ifdef SIG_CMN_CREDIT_TX_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  sig_cmn_rv_credit_tx_if #(.DWIDTH(DW), .CWIDTH(CW)) io ();
  sig_cmn_rv_credit_tx #(.DWIDTH(DW), .NUM_CREDITS(N)) dut (.clk(clk), .reset_n(reset_n), .io(io.slave));
  int errors = 0;
  int checks = 0;
  logic [3:0] dly = '0;
  logic echo_en = 1'b0;
  logic ret_man = 1'b0;
  logic [DW-1:0] rx_q[$];
  assign io.credit_ret_in = echo_en ? dly[3] : ret_man;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: credit count as an integer, plus "reloading" and "draining" flags.
  int m_cred;
  logic m_load, m_drain, m_lv, m_done, m_err;
  logic [DW-1:0] m_ld;
  wire m_ready = !m_load && !m_drain && m_cred != 0 && !io.reinit_req_in;
  wire m_send = io.valid_in && m_ready;
  wire [31:0] m_sum = 32'(m_cred - int'(m_send) + int'(io.credit_ret_in));
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m_cred <= 0; m_load <= 1'b1; m_drain <= 1'b0;
      m_lv <= 1'b0; m_ld <= '0; m_done <= 1'b0; m_err <= 1'b0;
    end else begin
      m_lv <= m_send;
      if (m_send) m_ld <= io.data_in;
      m_done <= m_load;
      if (m_load) begin
        m_cred <= N;
        m_load <= 1'b0;
        if (io.credit_ret_in) m_err <= 1'b1;
      end else begin
        m_cred <= (m_sum > N) ? N : int'(m_sum);
        if (m_sum > N) m_err <= 1'b1;
        if (m_drain && m_cred == N) begin
          m_drain <= 1'b0;
          m_load <= 1'b1;
        end else if (!m_drain && io.reinit_req_in) m_drain <= 1'b1;
      end
    end
  always @(negedge clk) begin
    check("ready_out", io.ready_out, m_ready);
    check("link_valid_out", io.link_valid_out, m_lv);
    check("link_data_out", io.link_data_out, m_ld);
    check("credits_out", io.credits_out, m_cred);
    check("reinit_done_out", io.reinit_done_out, m_done);
    check("err_out", io.err_out, ERR_EN & m_err);
    if (io.link_valid_out) rx_q.push_back(io.link_data_out);
    dly <= {dly[2:0], io.link_valid_out};
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset_n = 1'b0;
    tick;
    @(negedge clk);
    reset_n = 1'b1;
    tick;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int cnt, drops, minc;
    logic hs;
    logic [DW-1:0] x;
    io.valid_in = 1'b0; io.data_in = '0; io.reinit_req_in = 1'b0;
    repeat (2) tick;
    check("rst_ready", io.ready_out, 0);
    check("rst_credits", io.credits_out, 0);
    check("rst_link_valid", io.link_valid_out, 0);
    check("rst_link_data", io.link_data_out, 0);
    check("rst_done", io.reinit_done_out, 0);
    check("rst_err", io.err_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick;
    check("init_done_cycle1", io.reinit_done_out, 1);
    check("init_credits", io.credits_out, N);
    // Hold valid with no returns: exactly N beats, then stall.
    io.valid_in = 1'b1;
    cnt = 0;
    repeat (20) begin
      io.data_in = $urandom;
      tick;
      if (io.link_valid_out) cnt++;
    end
    check("fill_beats", cnt, N);
    check("fill_ready", io.ready_out, 0);
    check("fill_credits", io.credits_out, 0);
    io.valid_in = 1'b0;
    // Stream 1..32 with returns echoing link_valid_out four cycles late.
    do_reset;
    echo_en = 1'b1;
    rx_q.delete();
    drops = 0;
    minc = 99;
    for (int v = 1; v <= 32; v++) begin
      io.valid_in = 1'b1;
      io.data_in = DW'(v);
      hs = 1'b0;
      for (int k = 0; k < 20 && !hs; k++) begin
        @(negedge clk);
        hs = io.ready_out;
        if (!hs) drops++;
        if (int'(io.credits_out) < minc) minc = int'(io.credits_out);
        tick;
      end
      check("stream_accept", hs, 1);
    end
    io.valid_in = 1'b0;
    repeat (10) tick;
    check("stream_count", rx_q.size(), 32);
    for (int i = 0; i < 32 && i < rx_q.size(); i++) check("stream_order", rx_q[i], i + 1);
    check("stream_no_drop", drops, 0);
    check("stream_min_ge4", minc >= 4, 1);
    check("stream_min_eq4", minc, 4);
    check("stream_credits_back", io.credits_out, N);
    echo_en = 1'b0;
    // Send and return in the same cycle at credits == 3.
    do_reset;
    io.valid_in = 1'b1;
    repeat (5) begin
      io.data_in = $urandom;
      tick;
    end
    check("pre_simul_credits", io.credits_out, 3);
    x = 32'hA5A5_0003;
    io.data_in = x;
    ret_man = 1'b1;
    tick;
    io.valid_in = 1'b0;
    ret_man = 1'b0;
    check("simul_credits", io.credits_out, 3);
    check("simul_data", io.link_data_out, x);
    check("simul_valid", io.link_valid_out, 1);
    // Reinit with 5 credits outstanding.
    io.valid_in = 1'b1;
    io.reinit_req_in = 1'b1;
    #1;
    check("reinit_ready_now", io.ready_out, 0);
    tick;
    io.reinit_req_in = 1'b0;
    repeat (4) tick;
    check("drain_hold_credits", io.credits_out, 3);
    check("drain_hold_done", io.reinit_done_out, 0);
    check("drain_hold_ready", io.ready_out, 0);
    ret_man = 1'b1;
    repeat (5) tick;
    ret_man = 1'b0;
    hs = 1'b0;
    for (int i = 0; i < 10 && !hs; i++) begin
      tick;
      hs = io.reinit_done_out;
    end
    check("drain_done_seen", hs, 1);
    check("drain_done_credits", io.credits_out, N);
    io.valid_in = 1'b0;
    // Extra return at full credit.
    ret_man = 1'b1;
    tick;
    ret_man = 1'b0;
    check("overflow_credits", io.credits_out, N);
    check("overflow_err", io.err_out, ERR_EN);
    repeat (5) tick;
    check("overflow_err_sticky", io.err_out, ERR_EN);
    // Random traffic, returns and occasional reinit requests.
    do_reset;
    check("err_cleared_by_reset", io.err_out, 0);
    repeat (3000) begin
      io.valid_in = $urandom_range(0, 3) != 0;
      io.data_in = $urandom;
      ret_man = $urandom_range(0, 2) == 0;
      io.reinit_req_in = $urandom_range(0, 63) == 0;
      tick;
    end
    io.valid_in = 1'b0; ret_man = 1'b0; io.reinit_req_in = 1'b0;
    // Asynchronous reset mid-stream with 3 beats outstanding.
    do_reset;
    io.valid_in = 1'b1;
    repeat (3) begin
      io.data_in = $urandom;
      tick;
    end
    check("pre_areset_credits", io.credits_out, N - 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_valid", io.link_valid_out, 0);
    check("areset_data", io.link_data_out, 0);
    check("areset_credits", io.credits_out, 0);
    check("areset_ready", io.ready_out, 0);
    check("areset_done", io.reinit_done_out, 0);
    check("areset_err", io.err_out, 0);
    io.valid_in = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick;
    check("areset_reload_credits", io.credits_out, N);
    check("areset_reload_done", io.reinit_done_out, 1);
    repeat (2) tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sig_cmn_rv_credit_tx.md
Name: sig_cmn_rv_credit_tx

Overview:
- Transmit end of the team's credit-flow-controlled link. Converts an upstream valid/ready stream into a registered valid/data link with no backpressure signal.
- Flow control comes from credit-return pulses sent by the far-end receiver buffer.
- Sits between a valid/ready pipeline and a long or retimed link. Supports a drain-and-reinitialise handshake for link retraining.

Parameters:
- DWIDTH, 32, payload width in bits.
- NUM_CREDITS, 8, receiver buffer depth; initial and maximum credit count; range 1..255.
- CWIDTH, $clog2(NUM_CREDITS+1), credit counter width; derived, not overridden.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- valid_in  input  1  upstream data valid
- ready_out  output  1  upstream ready; a transfer occurs when valid_in && ready_out
- data_in  input  DWIDTH  upstream payload
- link_valid_out  output  1  link beat valid, registered
- link_data_out  output  DWIDTH  link payload, registered
- credit_ret_in  input  1  one-cycle pulse; returns one credit per asserted cycle
- reinit_req_in  input  1  level request to drain and reload credits
- reinit_done_out  output  1  one-cycle pulse when reload completes
- credits_out  output  CWIDTH  current available credit count
- err_out  output  1  sticky credit-overflow error (see Optional Feature)

Behaviour:
- Reset: one clock and async active-low reset (clk, reset_n), asserted asynchronously. Values during reset:
  - state = INIT
  - credits = 0
  - link_valid_out = 0, link_data_out = 0
  - ready_out = 0, reinit_done_out = 0, err_out = 0
- FSM states: INIT, RUN, DRAIN.
  - INIT: lasts exactly one cycle. Loads credits = NUM_CREDITS, pulses reinit_done_out, moves to RUN.
  - RUN: ready_out = (credits != 0) && !reinit_req_in. This is combinational from registered state plus reinit_req_in; there is no path from valid_in.
    - If reinit_req_in = 1, go to DRAIN next cycle.
  - DRAIN: ready_out = 0; no new beats are sent. Stay until credits == NUM_CREDITS (all outstanding credits returned), then go to INIT.
    - If already full on entry, DRAIN lasts one cycle.
    - Deasserting reinit_req_in during DRAIN does not abort the drain.
- Send: on an accepted transfer, link_valid_out = 1 and link_data_out = data_in on the next edge (latency 1). Otherwise link_valid_out = 0 and link_data_out holds its last value.
- Credit update, every cycle: credits_next = credits - send + ret, where send = valid_in && ready_out and ret = credit_ret_in.
  - Simultaneous send and return leaves the count unchanged.
  - Send at credits == 1 with no return: count goes to 0 and ready_out drops next cycle.
  - A return at credits == 0 re-enables ready_out the following cycle.
- Credit returns are counted in all states except INIT.
  - In INIT the load takes precedence; a same-cycle return is discarded.
- Overflow: a return that would make credits exceed NUM_CREDITS saturates the count at NUM_CREDITS.
- Full throughput: with the receiver returning one credit per cycle, one beat per cycle is sustained after the NUM_CREDITS-beat pipeline fill.
- credits_out equals the internal counter (registered).

Optional Feature:
- Macro: SIG_CMN_CREDIT_TX_ERR_EN.
- When defined:
  - err_out is set on any saturating overflow return, or on a return while in INIT.
  - err_out stays set until reset_n.
  - A simulation assertion checks that send never occurs with credits == 0.
- When undefined: err_out is tied to 0, and no error logic or assertions are present.

Decomposition:
- Shared package sig_cmn_pkg:
  - typedef enum logic [1:0] {CTX_INIT, CTX_RUN, CTX_DRAIN} credit_tx_state_e
  - function for the counter width calculation
- One natural sub-module: sig_cmn_credit_counter (saturating up/down counter with load, count, saturate flag). Reused later by the receiver side.

Test Plan:
- Reset then valid_in held 1, no returns, NUM_CREDITS=8:
  - reinit_done_out pulses in cycle 1.
  - Exactly 8 beats appear on link_valid_out, then ready_out = 0 and credits_out = 0.
- Stream 0x1..0x20 with credit_ret_in echoing link_valid_out delayed 4 cycles:
  - all 32 beats arrive in order;
  - no ready_out drop after fill;
  - credits_out never below 4.
- credits = 3 with send and credit_ret_in in the same cycle -> credits_out stays 3; link_data_out equals data_in from the previous cycle.
- reinit_req_in pulsed with 5 credits outstanding:
  - ready_out = 0 immediately;
  - FSM stays in DRAIN until 5 returns;
  - INIT then pulses reinit_done_out and credits_out = 8.
- Extra credit_ret_in at credits_out = 8:
  - count stays 8;
  - with SIG_CMN_CREDIT_TX_ERR_EN, err_out = 1 and remains set until reset_n.
- reset_n asserted mid-stream with 3 beats outstanding -> all outputs clear asynchronously; after release, INIT reloads 8 credits.
